// File: rtl/q2_pkg.sv
// q2_pkg: shared op encodings and sequencer state enum for the q2 datapath.
package q2_pkg;
    typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_NOR = 2'b01, OP_ADD = 2'b10, OP_SHR = 2'b11} op_e;
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} seq_state_e;
endpackage

// File: rtl/q2_serial_seq_if.sv
// q2_serial_seq_if: word-level request/result bus between instruction decode and the sequencer.
interface q2_serial_seq_if #(parameter int WIDTH = 8);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] acc;
    logic             flag;
    logic             zero;
    modport master(output start, op, operand, cin, input busy, done, acc, flag, zero);
    modport slave(input start, op, operand, cin, output busy, done, acc, flag, zero);
endinterface

// File: rtl/q2_shreg.sv
// q2_shreg: right shift register with parallel load and serial-in at the MSB.
module q2_shreg #(parameter int WIDTH = 8) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic             sin,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else if (load) q <= d;
        else if (shift) q <= {sin, q[WIDTH-1:1]};
endmodule

// File: rtl/q2_serial_seq.sv
// q2_serial_seq: bit-serial sequencer streaming A and X LSB-first through the q2 ALU.
// Define Q2_SEQ_ZERO_EN to build the result-was-zero register; otherwise zero is tied low.
module q2_serial_seq
    import q2_pkg::*;
#(parameter int WIDTH = 8) (
    input  logic              clk,
    input  logic              rst_n,
    q2_serial_seq_if.slave    bus,
    output logic              alu_a0,
    output logic              alu_x0,
    output logic              alu_x1,
    output logic              alu_f,
    output logic              alu_o0,
    output logic              alu_o1,
    input  logic              alu_out,
    input  logic              alu_cout
);
    localparam int CW = $clog2(WIDTH);
    seq_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q;
    op_e              op_q;
    logic             f_q;
    logic [WIDTH-1:0] a_q, x_q;
    logic             accept, shifting, last, unused_x;
    assign accept   = state_q == S_IDLE && bus.start;
    assign shifting = state_q == S_SHIFT;
    assign last     = cnt_q == CW'(WIDTH - 1);
    // A is never parallel-loaded: it only changes through the ALU result stream.
    q2_shreg #(.WIDTH(WIDTH)) u_a (.clk, .rst_n, .load(1'b0), .shift(shifting), .sin(alu_out), .d('0), .q(a_q));
    q2_shreg #(.WIDTH(WIDTH)) u_x (.clk, .rst_n, .load(accept), .shift(shifting), .sin(1'b0), .d(bus.operand), .q(x_q));
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= S_IDLE;
        else state_q <= state_d;
    always_comb begin
        state_d = state_q;
        if (accept) state_d = S_SHIFT;
        else if (shifting && last) state_d = S_DONE;
        else if (state_q == S_DONE) state_d = S_IDLE;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt_q <= '0;
            op_q  <= OP_LOAD;
            f_q   <= 1'b0;
        end else if (accept) begin
            cnt_q <= '0;
            op_q  <= op_e'(bus.op);
            f_q   <= bus.cin;
        end else if (shifting) begin
            cnt_q <= last ? cnt_q : cnt_q + CW'(1);
            f_q   <= alu_cout;
        end
`ifdef Q2_SEQ_ZERO_EN
    logic zero_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) zero_q <= 1'b0;
        else if (accept) zero_q <= 1'b1;
        else if (shifting && alu_out) zero_q <= 1'b0;
    assign bus.zero = zero_q;
`else
    assign bus.zero = 1'b0;
`endif
    assign bus.busy = shifting || state_q == S_DONE;
    assign bus.done = state_q == S_DONE;
    assign bus.acc  = a_q;
    assign bus.flag = f_q;
    assign alu_a0   = a_q[0];
    assign alu_x0   = x_q[0];
    assign alu_x1   = x_q[1];
    assign alu_f    = f_q;
    assign {alu_o1, alu_o0} = op_q;
    assign unused_x = ^x_q;
endmodule

// File: doc/q2_serial_seq.md
# q2_serial_seq

Bit-serial sequencer that owns the accumulator, operand shift register and flag register of the q2 datapath, and drives the bit-serial ALU one bit per clock. It latches an operation and operand on a start handshake and streams WIDTH bits LSB-first through the ALU. Each result bit is shifted back into the accumulator and each carry is captured into the flag. It sits directly upstream and downstream of the ALU, between instruction decode and the ALU slice.

## Interface
- WIDTH, default 8, datapath word width in bits; legal range 2 to 32.
- clk  in  1  the only clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  request a word operation; accepted only in IDLE.
- op  in  2  operation, latched on accept: 00 LOAD, 01 NOR, 10 ADD, 11 SHR.
- operand  in  WIDTH  X operand, latched on accept.
- cin  in  1  initial flag value, latched into F on accept.
- busy  out  1  high in SHIFT and DONE.
- done  out  1  one-cycle pulse in DONE.
- acc  out  WIDTH  accumulator A, registered.
- flag  out  1  flag register F, registered.
- zero  out  1  result-was-zero indicator; see Configuration.
- alu_a0, alu_x0, alu_x1, alu_f, alu_o0, alu_o1  out  1 each  bit-slice drive to the ALU.
- alu_out, alu_cout  in  1 each  ALU result bit and carry-out bit.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE, start=1: latch op, set X to operand, set F to cin, clear bit counter, go to SHIFT. A is not changed.
- SHIFT, each cycle:
  - A becomes {alu_out, A[WIDTH-1:1]}.
  - X becomes {0, X[WIDTH-1:1]}.
  - F becomes alu_cout.
  - Counter increments.
  - After the cycle with counter = WIDTH-1, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- ALU drive, combinational from registers: alu_a0=A[0], alu_x0=X[0], alu_x1=X[1], alu_f=F, {alu_o1,alu_o0}=latched op.
- ALU inputs are sampled only in SHIFT and ignored in all other states.
- Resulting word semantics, which the bench checks:
  - LOAD: A=X; F = cin AND (A==0).
  - NOR: A=~(A|X); F = cin AND (result==0).
  - ADD: A = A+X+cin mod 2^WIDTH; F = carry out.
  - SHR: A = X>>1 (logical, zero into MSB); F = cin unchanged.
- start is ignored in SHIFT and DONE; there is no queueing.
- Counter width is clog2(WIDTH); it never wraps within an operation.

## Timing
- Reset values: state IDLE, A=0, X=0, F=0, counter 0, op 00, busy 0, done 0, zero 0.
- Reset asserted mid-SHIFT aborts the operation immediately; no done pulse is produced.
- start accepted at edge N: SHIFT occupies edges N+1 to N+WIDTH, and done is high in the cycle after edge N+WIDTH.
- Fixed latency: WIDTH+1 cycles from accept to done.
- Back-to-back throughput: one operation per WIDTH+2 cycles; the earliest next accept is the first IDLE cycle after DONE.
- acc, flag and zero are stable and final when done=1, and hold until the next accept.

## Configuration
- Q2_SEQ_ZERO_EN defined:
  - A zero-tracking register is set on accept.
  - It is cleared in any SHIFT cycle with alu_out=1.
  - zero reflects the final word from DONE onward and holds until the next accept.
- Q2_SEQ_ZERO_EN undefined: no register is built and zero is tied to 0.

## Structure
- Shared package q2_pkg holds:
  - op encodings OP_LOAD, OP_NOR, OP_ADD, OP_SHR;
  - the sequencer state enum.
- One sub-module is natural: q2_shreg, a WIDTH-bit right shift register with parallel load and serial-in, instantiated for A and for X.
- The FSM and counter stay in the top module.

## Test plan
All scenarios use WIDTH=8.
- LOAD operand=0xA5, cin=1: acc=0xA5, flag=0, zero=0; done exactly 9 cycles after accept.
- After that, ADD operand=0x5B, cin=0: acc=0x00, flag=1, zero=1 (with _EN).
- acc=0x0F, NOR operand=0x30, cin=1: acc=0xC0, flag=0.
- SHR operand=0x81, cin=1: acc=0x40, flag=1.
- start pulsed during SHIFT with other op/operand: ignored, result unchanged. Back-to-back start held high: second accept occurs on the first IDLE cycle, and ops complete at cycles 9 and 19.
- rst_n low after 3 SHIFT edges: acc=0, flag=0, busy=0 immediately, no done pulse. A following LOAD 0x3C completes normally with acc=0x3C.
